// File: rtl/mem_bist_engine.sv
// mem_bist_engine: march-style memory self-test engine.
// It writes a selectable pattern to every address, then reads each address back
// and compares the data with the same pattern. It counts the mismatches and
// captures the address and data of the first mismatch in each run.
// Build option: with MEM_BIST_STOP_ON_FAIL_EN defined, the run ends at the first mismatch.
module mem_bist_engine #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [2:0]        WAIT_LEN  = 3'(RD_LAT - 1);

    state_t              state, state_next;
    logic [1:0]          mode_q;
    logic [2:0]          wait_cnt;
    logic [DATA_W-1:0]   expected;
    logic                mismatch;
    logic                start_accept;

    // Test pattern for address a under pattern select m.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        p = '0;
        case (m)
            2'd0: p = '0;
            2'd1: p = DATA_W'(a);
            2'd2: for (int i = 0; i < DATA_W; i++) p[i] = a[0] ^ ~i[0];
            default: for (int i = 0; i < DATA_W; i++) p[i] = ((int'(a) % DATA_W) == i);
        endcase
        return p;
    endfunction

    assign expected     = pattern(mode_q, addr);
    // The comparison is 4-state, so an X or Z bit read back from the memory counts as a failure.
    assign mismatch     = (data_out !== expected);
    assign start_accept = start && (state == S_IDLE || state == S_DONE);

    // State register.
    // NOTE: use non-blocking (<=) for every flop so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    // NOTE: assign every output a default first so no path through the block infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_WRITE;
            S_WRITE:        if (addr == LAST_ADDR) state_next = S_READ;
            S_READ:         state_next = (RD_LAT == 1) ? S_CHECK : S_WAIT;
            S_WAIT:         if (wait_cnt == 3'd1) state_next = S_CHECK;
            S_CHECK: begin
`ifdef MEM_BIST_STOP_ON_FAIL_EN
                if (mismatch || addr == LAST_ADDR) state_next = S_DONE;
                else                               state_next = S_READ;
`else
                if (addr == LAST_ADDR) state_next = S_DONE;
                else                   state_next = S_READ;
`endif
            end
            default:        state_next = S_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        read    = 1'b0;
        write   = 1'b0;
        data_in = '0;
        case (state)
            S_WRITE: begin
                write   = 1'b1;
                data_in = expected;
            end
            S_READ:  read = 1'b1;
            default: ;
        endcase
        busy = (state == S_WRITE) || (state == S_READ) || (state == S_WAIT) || (state == S_CHECK);
        done = (state == S_DONE);
        pass = done && (err_count == 16'd0);
    end

    // Datapath: address walk, read-latency counter, error count and first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            mode_q    <= 2'd0;
            wait_cnt  <= 3'd0;
            err_count <= 16'd0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (start_accept) begin
            addr      <= '0;
            mode_q    <= mode;
            wait_cnt  <= 3'd0;
            err_count <= 16'd0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            case (state)
                S_WRITE: begin
                    if (addr == LAST_ADDR) addr <= '0;
                    else                   addr <= addr + 1'b1;
                end
                S_READ:  wait_cnt <= WAIT_LEN;
                S_WAIT:  wait_cnt <= wait_cnt - 3'd1;
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        // A zero count means this is the first mismatch of the run (the count saturates and never wraps back to zero).
                        if (err_count == 16'd0) begin
                            fail_addr <= addr;
                            fail_data <= data_out;
                        end
                    end
                    if (state_next == S_READ) addr <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_engine.sv
// tb_mem_bist_engine: scoreboard bench for mem_bist_engine with a behavioural memory.
// The memory model can hold stuck-at-0 faults. Each run pushes its expected results
// into a queue, and a monitor pops and compares them when done rises.
module tb_mem_bist_engine;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic              read, write, busy, done, pass;
    logic [ADDR_W-1:0] addr, fail_addr;
    logic [DATA_W-1:0] data_in, data_out, fail_data;
    logic [15:0]       err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bist_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    // Behavioural memory with one-cycle read latency and stuck-at-0 faults applied on read.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] all_mask = '0;
    logic [DATA_W-1:0] one_mask = '0;
    int                one_addr = -1;

    assign data_out = rdata;

    function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem[a] & ~all_mask;
        if (int'(a) == one_addr) v = v & ~one_mask;
        return v;
    endfunction

    always @(posedge clk) begin
        if (write) mem[addr] <= data_in;
        if (read)  rdata <= rd_model(addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string             name;
        logic [15:0]       err;
        logic [ADDR_W-1:0] faddr;
        logic [DATA_W-1:0] fdata;
        logic              pass;
        int                cycles;
        int                ca0;
        logic [DATA_W-1:0] cv0;
        int                ca1;
        logic [DATA_W-1:0] cv1;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t mk(input string name, input int err, input int fa, input int fd, input bit p,
                                input int cyc, input int ca0, input int cv0, input int ca1, input int cv1);
        exp_t e;
        e.name   = name;
        e.err    = 16'(err);
        e.faddr  = ADDR_W'(fa);
        e.fdata  = DATA_W'(fd);
        e.pass   = p;
        e.cycles = cyc;
        e.ca0    = ca0;
        e.cv0    = DATA_W'(cv0);
        e.ca1    = ca1;
        e.cv1    = DATA_W'(cv1);
        return e;
    endfunction

    // Monitor: count busy cycles and score each run when done rises.
    int busy_cycles = 0;
    logic prev_done = 1'b0;
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cycles = 0;
                prev_done   = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (done && !prev_done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_err_count"}, 32'(err_count), 32'(e.err));
                        check({e.name, "_fail_addr"}, 32'(fail_addr), 32'(e.faddr));
                        check({e.name, "_fail_data"}, 32'(fail_data), 32'(e.fdata));
                        check({e.name, "_pass"},      32'(pass),      32'(e.pass));
                        check({e.name, "_cycles"},    32'(busy_cycles), 32'(e.cycles));
                        check({e.name, "_mem_a"},     32'(mem[e.ca0]), 32'(e.cv0));
                        check({e.name, "_mem_b"},     32'(mem[e.ca1]), 32'(e.cv1));
                    end
                    busy_cycles = 0;
                end
                prev_done = done;
            end
        end
    end

    // Issue one run. Optionally pulse start again while busy. Wait for done within a bounded time.
    task automatic run(input logic [1:0] m, input exp_t e, input bit poke);
        bit got;
        got = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (10) @(negedge clk);
            mode  = ~m;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            check({e.name, "_timeout"}, 32'(done), 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_read"},      32'(read),      32'd0);
        check({tag, "_write"},     32'(write),     32'd0);
        check({tag, "_addr"},      32'(addr),      32'd0);
        check({tag, "_data_in"},   32'(data_in),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_pass"},      32'(pass),      32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
        check({tag, "_fail_data"}, 32'(fail_data), 32'd0);
    endtask

    initial begin : stimulus
        bit hit;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(2'd0, mk("mode0", 0, 0, 0, 1'b1, 96, 5, 8'h00, 20, 8'h00), 1'b0);
        run(2'd1, mk("mode1", 0, 0, 0, 1'b1, 96, 17, 8'h11, 31, 8'h1F), 1'b0);
        run(2'd2, mk("mode2", 0, 0, 0, 1'b1, 96, 2, 8'h55, 3, 8'hAA), 1'b0);

        // Bit 3 stuck-at-0 at address 9: pattern 0x09 reads back as 0x01.
        one_addr = 9;
        one_mask = 8'h08;
`ifdef MEM_BIST_STOP_ON_FAIL_EN
        run(2'd1, mk("stuck9", 1, 9, 8'h01, 1'b0, 52, 9, 8'h09, 10, 8'h0A), 1'b0);
`else
        run(2'd1, mk("stuck9", 1, 9, 8'h01, 1'b0, 96, 9, 8'h09, 10, 8'h0A), 1'b0);
`endif
        one_addr = -1;
        one_mask = '0;

        // Bit 0 stuck-at-0 everywhere with walking ones: fails at addresses 0, 8, 16 and 24.
        all_mask = 8'h01;
`ifdef MEM_BIST_STOP_ON_FAIL_EN
        run(2'd3, mk("walk_b0", 1, 0, 8'h00, 1'b0, 34, 0, 8'h01, 1, 8'h02), 1'b0);
`else
        run(2'd3, mk("walk_b0", 4, 0, 8'h00, 1'b0, 96, 8, 8'h01, 9, 8'h02), 1'b0);
`endif
        all_mask = '0;

        // A start pulse in the middle of the write phase must not restart or alter the run.
        run(2'd1, mk("poke", 0, 0, 0, 1'b1, 96, 12, 8'h0C, 30, 8'h1E), 1'b1);

        // Reset in the middle of the read phase, at address 12, with a failure already recorded (default build).
`ifndef MEM_BIST_STOP_ON_FAIL_EN
        one_addr = 9;
        one_mask = 8'h08;
`endif
        @(negedge clk);
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (read && addr == ADDR_W'(12)) hit = 1'b1;
        end
        check("reset_mid_reached", 32'(hit), 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        one_addr = -1;
        one_mask = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run(2'd1, mk("after_reset", 0, 0, 0, 1'b1, 96, 17, 8'h11, 31, 8'h1F), 1'b0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bist_engine.md
MEM_BIST_ENGINE -- requirements
Module: mem_bist_engine

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width; the engine covers depth 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter RD_LAT, default 1, range 1..4, cycles from read assertion to valid data_out.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin a test run; sampled only in IDLE or DONE.
REQ-007 mode  input  2  pattern select, latched on accepted start.
REQ-008 read  output  1  memory read strobe.
REQ-009 write  output  1  memory write strobe.
REQ-010 addr  output  ADDR_W  memory address.
REQ-011 data_in  output  DATA_W  write data to memory.
REQ-012 data_out  input  DATA_W  read data from memory.
REQ-013 busy  output  1  test run in progress.
REQ-014 done  output  1  run complete; held until next accepted start or reset.
REQ-015 pass  output  1  equals done AND err_count==0.
REQ-016 err_count  output  16  mismatch count, saturating at 16'hFFFF.
REQ-017 fail_addr  output  ADDR_W  address of first mismatch.
REQ-018 fail_data  output  DATA_W  data read at first mismatch.

Function
REQ-019 FSM states: IDLE, WRITE, READ, WAIT, CHECK, DONE.
REQ-020 IDLE/DONE + start=1: clear err_count, fail_addr, fail_data, done; latch mode; enter WRITE with addr=0; busy=1 from next cycle.
REQ-021 start while busy=1 is ignored.
REQ-022 WRITE: one address per cycle, write=1, read=0, addr 0 to 2**ADDR_W-1 ascending; after last address, go to READ with addr=0.
REQ-023 Pattern P(a): mode 0 all zeros; mode 1 a zero-extended or truncated to DATA_W; mode 2 {0x55..} when a[0]=0, {0xAA..} when a[0]=1; mode 3 one-hot bit (a mod DATA_W).
REQ-024 READ: one cycle, read=1, write=0, addr=a; then WAIT for RD_LAT-1 cycles (none when RD_LAT=1).
REQ-025 CHECK: data_out is sampled on the edge ending the cycle RD_LAT cycles after the read cycle, then compared with P(a) using 4-state inequality.
REQ-026 Each address costs 1+RD_LAT cycles; the next READ follows CHECK directly.
REQ-027 On mismatch: err_count increments unless saturated; if this is the first mismatch of the run, capture fail_addr=a and fail_data=data_out.
REQ-028 After CHECK of the last address: enter DONE, busy=0, done=1.
REQ-029 Total run length = 2**ADDR_W*(2+RD_LAT) cycles from first busy cycle to first done cycle.
REQ-030 Outside WRITE/READ: read=0, write=0, data_in=0; addr holds its last value.

Reset
REQ-031 rst=1 forces IDLE immediately, regardless of clock.
REQ-032 Reset values: read=0, write=0, addr=0, data_in=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0, fail_data=0.
REQ-033 Reset mid-run abandons the run with no partial done; the first start after release runs a full fresh test.

Configuration
REQ-034 Macro MEM_BIST_STOP_ON_FAIL_EN defined: the first mismatch moves CHECK to DONE at once; err_count=1, pass=0, remaining addresses are skipped.
REQ-035 MEM_BIST_STOP_ON_FAIL_EN undefined: all addresses are checked and every mismatch is counted.

Verification (ADDR_W=5, DATA_W=8, RD_LAT=1, behavioural memory)
REQ-036 Fault-free memory, mode 0 -> done after 96 cycles, pass=1, err_count=0.
REQ-037 Mode 1 -> address 17 written 0x11, address 31 read back 0x1F, pass=1.
REQ-038 Mode 2 -> address 2 written/expected 0x55, address 3 0xAA, pass=1.
REQ-039 Bit 3 stuck-at-0 at address 9, mode 1 -> fail_addr=9, fail_data=0x01, err_count=1, pass=0.
REQ-040 Bit 0 stuck-at-0 at all addresses, mode 3 -> macro undefined: err_count=4 (addresses 0, 8, 16, 24), fail_addr=0; macro defined: done directly after address 0 check, err_count=1.
REQ-041 start pulse during WRITE -> ignored; rst at address 12 of READ -> all outputs zero the same cycle, busy=0; new start -> full 96-cycle run, pass=1.
